// File: rtl/lbuf_addr_rcv_pkg.sv
// Shared constants, FSM state encoding and the DW byte-swap helper for the lbuf
// address receiver.
package lbuf_addr_rcv_pkg;

  localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'h40;
  localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'h60;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A32   = 3'd1,
    A64   = 3'd2,
    D32   = 3'd3,
    D64   = 3'd4,
    DRAIN = 3'd5
  } lbuf_state_e;

  // TRN payload DWs arrive big-endian; the host wrote little-endian values.
  function automatic logic [31:0] dw_swap(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/lbuf_addr_rcv_if.sv
// TRN rx snoop bus plus the lbuf address handshake. lbuf_drop_cnt exists only
// when LBUF_DROP_CNT_EN is defined.
interface lbuf_addr_rcv_if;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic [6:0]  trn_rbar_hit_n;
  logic [63:0] lbuf_addr;
  logic        lbuf_valid;
  logic        lbuf_ack;
  logic        lbuf_en;
`ifdef LBUF_DROP_CNT_EN
  logic [15:0] lbuf_drop_cnt;
`endif

  modport master (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
    output trn_rbar_hit_n, lbuf_ack,
    input  lbuf_addr, lbuf_valid, lbuf_en
`ifdef LBUF_DROP_CNT_EN
    , input lbuf_drop_cnt
`endif
  );

  modport slave (
    input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
    input  trn_rbar_hit_n, lbuf_ack,
    output lbuf_addr, lbuf_valid, lbuf_en
`ifdef LBUF_DROP_CNT_EN
    , output lbuf_drop_cnt
`endif
  );

endinterface

// File: rtl/lbuf_addr_rcv_fifo2.sv
// Two-entry 64-bit FIFO; head stays in mem0 so dout holds its last value when
// the FIFO drains. A push into a full FIFO without a pop is dropped.
module lbuf_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  logic [63:0] mem0;
  logic [63:0] mem1;
  logic [1:0]  count;
  logic        do_pop;
  logic        do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else if (do_pop && do_push) begin
      if (full) begin
        mem0 <= mem1;
        mem1 <= din;
      end else begin
        mem0 <= din;
      end
    end else if (do_pop) begin
      if (full) mem0 <= mem1;
      count <= count - 2'd1;
    end else if (do_push) begin
      if (empty) mem0 <= din;
      else       mem1 <= din;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/lbuf_addr_rcv.sv
// Passive TRN rx snooper: decodes host memory writes to one BAR, captures lbuf
// addresses into a 2-entry FIFO and the lbuf enable level. Optional LBUF_DROP_CNT_EN.
module lbuf_addr_rcv
  import lbuf_addr_rcv_pkg::*;
#(
  parameter int         BARHIT     = 2,
  parameter logic [5:0] BARMP_ADDR = 6'b000000,
  parameter logic [5:0] BARMP_EN   = 6'b000010
) (
  input logic           clk,
  input logic           rst_n,
  lbuf_addr_rcv_if.slave bus
);

  lbuf_state_e state, next_state;

  logic        rdy, sof, eof, hit;
  logic [6:0]  fmt_type;
  logic [9:0]  len_q, len_next;
  logic        sel_en_q, sel_en_next;
  logic [31:0] lo_q;
  logic [31:0] sw_hi, sw_lo;
  logic        lo_we;
  logic        en_we, en_val;
  logic        en_q;
  logic        push;
  logic [63:0] push_data;
  logic        fifo_full, fifo_empty, drop;

  assign rdy      = ~bus.trn_rsrc_rdy_n;
  assign sof      = ~bus.trn_rsof_n;
  assign eof      = ~bus.trn_reof_n;
  assign hit      = ~bus.trn_rbar_hit_n[BARHIT];
  assign fmt_type = bus.trn_rd[62:56];
  assign sw_hi    = dw_swap(bus.trn_rd[63:32]);
  assign sw_lo    = dw_swap(bus.trn_rd[31:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A sof beat always restarts decode, whatever state a previous TLP left us in.
  always_comb begin
    next_state  = state;
    len_next    = len_q;
    sel_en_next = sel_en_q;
    lo_we       = 1'b0;
    en_we       = 1'b0;
    en_val      = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    if (rdy) begin
      if (sof) begin
        next_state = IDLE;
        len_next   = bus.trn_rd[41:32];
        if (hit && !eof) begin
          if (fmt_type == MEM_WR32_FMT_TYPE)      next_state = A32;
          else if (fmt_type == MEM_WR64_FMT_TYPE) next_state = A64;
          else                                    next_state = DRAIN;
        end
      end else begin
        case (state)
          A32: begin
            if (bus.trn_rd[39:34] == BARMP_EN && len_q == 10'd1) begin
              en_we      = 1'b1;
              en_val     = sw_lo[0];
              next_state = IDLE;
            end else if (bus.trn_rd[39:34] == BARMP_ADDR && len_q == 10'd2 && !eof) begin
              lo_we      = 1'b1;
              next_state = D32;
            end else begin
              next_state = eof ? IDLE : DRAIN;
            end
          end
          D32: begin
            push       = 1'b1;
            push_data  = {sw_hi, lo_q};
            next_state = IDLE;
          end
          A64: begin
            if (!eof && bus.trn_rd[7:2] == BARMP_EN && len_q == 10'd1) begin
              sel_en_next = 1'b1;
              next_state  = D64;
            end else if (!eof && bus.trn_rd[7:2] == BARMP_ADDR && len_q == 10'd2) begin
              sel_en_next = 1'b0;
              next_state  = D64;
            end else begin
              next_state = eof ? IDLE : DRAIN;
            end
          end
          D64: begin
            if (sel_en_q) begin
              en_we  = 1'b1;
              en_val = sw_hi[0];
            end else begin
              push      = 1'b1;
              push_data = {sw_lo, sw_hi};
            end
            next_state = IDLE;
          end
          DRAIN:   if (eof) next_state = IDLE;
          default: next_state = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= '0;
      sel_en_q <= 1'b0;
      lo_q     <= '0;
      en_q     <= 1'b0;
    end else begin
      len_q    <= len_next;
      sel_en_q <= sel_en_next;
      if (lo_we) lo_q <= sw_lo;
      if (en_we) en_q <= en_val;
    end
  end

  lbuf_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (bus.lbuf_ack),
    .din   (push_data),
    .dout  (bus.lbuf_addr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (drop)
  );

  assign bus.lbuf_valid = ~fifo_empty;
  assign bus.lbuf_en    = en_q;

  logic unused_sigs;

`ifdef LBUF_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign bus.lbuf_drop_cnt = drop_cnt;
  assign unused_sigs = &{1'b0, bus.trn_rrem_n, bus.trn_rbar_hit_n, fifo_full};
`else
  assign unused_sigs = &{1'b0, bus.trn_rrem_n, bus.trn_rbar_hit_n, fifo_full, drop};
`endif

endmodule

// File: tb/tb_lbuf_addr_rcv.sv
// Directed bench for lbuf_addr_rcv with a queue scoreboard of expected FIFO
// contents; checks lbuf_drop_cnt when LBUF_DROP_CNT_EN is defined.
module tb_lbuf_addr_rcv;
  import lbuf_addr_rcv_pkg::*;

  localparam int         BARHIT     = 2;
  localparam logic [5:0] BARMP_ADDR = 6'b000000;
  localparam logic [5:0] BARMP_EN   = 6'b000010;
  localparam logic [6:0] HIT        = 7'b1111011;
  localparam logic [6:0] MISS       = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lbuf_addr_rcv_if bus();

  lbuf_addr_rcv #(.BARHIT(BARHIT), .BARMP_ADDR(BARMP_ADDR), .BARMP_EN(BARMP_EN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          drops = 0;
  logic        exp_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] last_head = '0;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len);
    return {1'b0, ft, 14'h0, len, 32'h0100_00FF};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] rd, input logic s, input logic e,
                               input logic [6:0] hit_n);
    bus.trn_rd         = rd;
    bus.trn_rsof_n     = ~s;
    bus.trn_reof_n     = ~e;
    bus.trn_rbar_hit_n = hit_n;
    bus.trn_rsrc_rdy_n = 1'b0;
    @(posedge clk);
    #1;
    bus.trn_rsrc_rdy_n = 1'b1;
  endtask

  task automatic stallCycle();
    bus.trn_rd         = 64'hDEAD_BEEF_CAFE_F00D;
    bus.trn_rsof_n     = 1'b0;
    bus.trn_reof_n     = 1'b0;
    bus.trn_rsrc_rdy_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic modelPush(input logic [63:0] a);
    if (exp_q.size() < 2) exp_q.push_back(a);
    else                  drops++;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus.lbuf_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      last_head = exp_q[0];
      checkOutput({tag, "_addr"}, bus.lbuf_addr, exp_q[0]);
    end else begin
      checkOutput({tag, "_addr_hold"}, bus.lbuf_addr, last_head);
    end
    checkOutput({tag, "_en"}, 64'(bus.lbuf_en), 64'(exp_en));
`ifdef LBUF_DROP_CNT_EN
    checkOutput({tag, "_dropcnt"}, 64'(bus.lbuf_drop_cnt), 64'(drops));
`endif
  endtask

  task automatic wr32Addr(input logic [63:0] a, input bit ack_last);
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd2), 1'b1, 1'b0, HIT);
    applyStimulus({32'hF000_0000 | {24'h0, BARMP_ADDR, 2'b00}, bswap(a[31:0])}, 1'b0, 1'b0, HIT);
    if (ack_last) begin
      bus.lbuf_ack = 1'b1;
      checkOutput("pushpop_head", bus.lbuf_addr, exp_q[0]);
    end
    applyStimulus({bswap(a[63:32]), 32'h0}, 1'b0, 1'b1, HIT);
    if (ack_last) begin
      bus.lbuf_ack = 1'b0;
      void'(exp_q.pop_front());
    end
    modelPush(a);
  endtask

  task automatic wr64Addr(input logic [63:0] a);
    applyStimulus(hdr(MEM_WR64_FMT_TYPE, 10'd2), 1'b1, 1'b0, HIT);
    applyStimulus({32'h0000_0000, 32'hF000_0000 | {24'h0, BARMP_ADDR, 2'b00}}, 1'b0, 1'b0, HIT);
    applyStimulus({bswap(a[31:0]), bswap(a[63:32])}, 1'b0, 1'b1, HIT);
    modelPush(a);
  endtask

  task automatic wr32En(input logic v);
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd1), 1'b1, 1'b0, HIT);
    applyStimulus({32'hF000_0000 | {24'h0, BARMP_EN, 2'b00}, bswap({31'h0, v})}, 1'b0, 1'b1, HIT);
    exp_en = v;
  endtask

  task automatic doAck(input string tag);
    bus.lbuf_ack = 1'b1;
    checkOutput({tag, "_pop"}, bus.lbuf_addr, exp_q[0]);
    @(posedge clk);
    #1;
    bus.lbuf_ack = 1'b0;
    last_head = exp_q[0];
    void'(exp_q.pop_front());
    checkState(tag);
  endtask

  initial begin
    bus.trn_rd         = '0;
    bus.trn_rrem_n     = '0;
    bus.trn_rsof_n     = 1'b1;
    bus.trn_reof_n     = 1'b1;
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rbar_hit_n = MISS;
    bus.lbuf_ack       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset");
    rst_n = 1'b1;

    // 32-bit address write, valid the cycle after the last beat
    wr32Addr(64'h0000_0001_1000_0000, 1'b0);
    checkState("wr32_addr");
    doAck("ack_first");

    // 64-bit enable write with a stalled (rdy_n=1, sof/eof active) cycle mid-TLP
    applyStimulus(hdr(MEM_WR64_FMT_TYPE, 10'd1), 1'b1, 1'b0, HIT);
    stallCycle();
    applyStimulus({32'h0000_0000, 32'hF000_0000 | {24'h0, BARMP_EN, 2'b00}}, 1'b0, 1'b0, HIT);
    applyStimulus({bswap(32'h0000_0001), 32'h0}, 1'b0, 1'b1, HIT);
    exp_en = 1'b1;
    checkState("wr64_en");

    // Overflow: third address dropped
    wr32Addr(64'hAAAA_0000_1111_2220, 1'b0);
    wr64Addr(64'hBBBB_0000_3333_4440);
    wr32Addr(64'hCCCC_0000_5555_6660, 1'b0);
    checkState("full_drop");
    doAck("ack_a");
    doAck("ack_b");
    bus.lbuf_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.lbuf_ack = 1'b0;
    checkState("ack_empty");

    // BAR miss, then wrong length to the address register
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd2), 1'b1, 1'b0, MISS);
    applyStimulus({32'hF000_0000, bswap(32'h1234_5678)}, 1'b0, 1'b0, MISS);
    applyStimulus({bswap(32'h9ABC_DEF0), 32'h0}, 1'b0, 1'b1, MISS);
    checkState("bar_miss");
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd1), 1'b1, 1'b0, HIT);
    applyStimulus({32'hF000_0000, bswap(32'h1234_5678)}, 1'b0, 1'b1, HIT);
    checkState("len1_addr");
    wr64Addr(64'h0123_4567_89AB_CDE0);
    checkState("after_miss");
    doAck("ack_d");

    // Early eof on the A32 beat, then a normal write
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd2), 1'b1, 1'b0, HIT);
    applyStimulus({32'hF000_0000, bswap(32'h7777_0000)}, 1'b0, 1'b1, HIT);
    checkState("early_eof");
    wr32Addr(64'h0000_0002_2000_0000, 1'b0);
    checkState("after_early");

    // Simultaneous push and pop while full
    wr32Addr(64'h0000_0003_3000_0000, 1'b0);
    wr32Addr(64'h0000_0004_4000_0000, 1'b1);
    checkState("pushpop_full");
    doAck("ack_g");
    doAck("ack_h");

    // Sof mid-TLP restarts decode
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd2), 1'b1, 1'b0, HIT);
    wr32Addr(64'h0000_0005_5000_0000, 1'b0);
    checkState("sof_restart");

    // Enable cleared, set again, then reset mid-TLP with one entry held
    wr32En(1'b0);
    checkState("en_clear");
    wr32En(1'b1);
    checkState("en_set");
    applyStimulus(hdr(MEM_WR32_FMT_TYPE, 10'd2), 1'b1, 1'b0, HIT);
    rst_n = 1'b0;
    applyStimulus({32'hF000_0000, bswap(32'h6000_0000)}, 1'b0, 1'b0, HIT);
    rst_n = 1'b1;
    exp_q.delete();
    exp_en = 1'b0;
    last_head = '0;
    drops = 0;
    checkState("reset_mid");
    applyStimulus({bswap(32'h0000_0006), 32'h0}, 1'b0, 1'b1, HIT);
    checkState("post_reset_tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lbuf_addr_rcv.md
Name: lbuf_addr_rcv

Overview:
- Sibling TRN-rx snooper on the same receive stream as the BAR lost-sync detector.
- Decodes host 32/64-bit memory writes to one BAR. Captures 64-bit lbuf addresses and the lbuf enable bit.
- Hands addresses to the downstream DMA engine through a 2-entry buffer with a valid/ack handshake.
- Passive: never back-pressures TRN.

Parameters:
- BARHIT, 2, index into trn_rbar_hit_n that selects the BAR.
- BARMP_ADDR, 6'b000000, DW-offset bits [7:2] of the 2-DW lbuf address register.
- BARMP_EN, 6'b000010, DW-offset bits [7:2] of the 1-DW enable register.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- trn_rd  in  64  TRN rx data
- trn_rrem_n  in  8  TRN rx remainder (unused except lint)
- trn_rsof_n  in  1  start of frame, active-low
- trn_reof_n  in  1  end of frame, active-low
- trn_rsrc_rdy_n  in  1  beat valid, active-low
- trn_rbar_hit_n  in  7  BAR hit, active-low
- lbuf_addr  out  64  head-of-buffer address
- lbuf_valid  out  1  buffer non-empty
- lbuf_ack  in  1  pop head when lbuf_valid=1
- lbuf_en  out  1  enable level written by host

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM returns to IDLE.
  - Buffer empties.
  - Outputs: lbuf_valid=0, lbuf_addr=0, lbuf_en=0.
- Beat acceptance:
  - A beat counts only when trn_rsrc_rdy_n=0.
  - With trn_rsrc_rdy_n=1, all state holds.
- Payload byte order: each payload DW is byte-swapped before use (PCIe big-endian to little-endian).
- Beat 0 (header) fields:
  - fmt/type = trn_rd[62:56].
  - length = trn_rd[41:32].
- FSM states: IDLE, A32, A64, D32, D64, DRAIN.
  - IDLE: sof & rdy & bar hit.
    - MEM_WR32 → A32.
    - MEM_WR64 → A64.
    - Otherwise → DRAIN, unless eof is on the same beat (then stay IDLE).
  - A32: offset = trn_rd[39:34]; first data DW = trn_rd[31:0].
    - Offset BARMP_EN with length 1: lbuf_en ← data bit0 → IDLE.
    - Offset BARMP_ADDR with length 2: latch low DW → D32.
    - Else → DRAIN, or IDLE if eof.
  - D32: high DW = trn_rd[63:32]; push {hi,lo} → IDLE.
  - A64: offset = trn_rd[7:2].
    - Matching register with correct length → D64.
    - Else → DRAIN/IDLE.
  - D64: trn_rd[63:32] = DW0, trn_rd[31:0] = DW1.
    - EN: lbuf_en ← DW0 bit0.
    - ADDR: push {DW1,DW0}.
    - → IDLE.
  - DRAIN: wait for eof beat → IDLE.
- Early eof (eof before the expected data beat): discard partial capture; no push, no lbuf_en change; → IDLE.
- sof seen in any non-IDLE state: abandon the current TLP and decode the new header as if in IDLE.
- Latency: lbuf_valid=1 the cycle after the final data beat, if the buffer was empty.
- Buffer: 2 entries, FIFO order.
  - Pop: lbuf_ack & lbuf_valid.
  - Simultaneous push and pop at full: both occur; the pushed entry is kept.
  - Push when full with no pop: the new address is dropped; existing entries are unchanged.
  - lbuf_ack with lbuf_valid=0: ignored.
  - lbuf_addr is valid only when lbuf_valid=1; it holds its last value otherwise.

Optional Feature:
- Macro: LBUF_DROP_CNT_EN.
- Defined: adds output lbuf_drop_cnt [15:0].
  - Increments by 1 on every dropped push.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no port, no counter; drops are silent.

Decomposition:
- Shared package/include: MEM_WR32_FMT_TYPE and MEM_WR64_FMT_TYPE constants, the FSM state encodings, and the DW byte-swap function.
- One sub-module, lbuf_fifo2: 2-entry, 64-bit FIFO with push/pop/full/empty and drop pulse.

Test Plan:
- 32-bit write to BARMP_ADDR, length 2, payload bytes giving lo=32'h1000_0000 and hi=32'h0000_0001 → next cycle lbuf_valid=1, lbuf_addr=64'h0000_0001_1000_0000.
- 64-bit write to BARMP_EN, DW0 bit0=1, with one rsrc_rdy_n=1 stall beat mid-TLP → lbuf_en=1 after the data beat; lbuf_valid stays 0.
- Three address writes, lbuf_ack held 0 → two entries are held in order; third is dropped; lbuf_drop_cnt=1 when macro defined. Then ack twice → first two addresses pop in order, then lbuf_valid=0.
- Address write with trn_rbar_hit_n[BARHIT]=1, or length=1 to BARMP_ADDR → no push; FSM back in IDLE after eof.
- Early eof on the A32 beat of an address write → no push; a following valid write is captured normally.
- rst_n=0 asserted mid-TLP with buffer holding 1 entry → lbuf_valid=0, lbuf_en=0 next cycle; the remainder of that TLP is ignored.
